clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Downstream consumer of the divided clock produced by the frequency-divider stages. Samples the divided clock as a data signal in the fast `clk` domain and emits one-cycle rise/fall ticks usable as clock enables. Measures period and high time, declares lock after a run of in-tolerance periods, and flags a stalled divider through a timeout.

## Interface
- `CNT_W`, 8: width of period/high-time counters and outputs.
- `EXP_PERIOD`, 4: expected divided-clock period in `clk` cycles.
- `TOL`, 0: allowed absolute deviation from `EXP_PERIOD`, in cycles.
- `LOCK_CNT`, 3: consecutive in-tolerance periods required to lock.
- `TIMEOUT`, 16: cycles without a rising edge before fault; must satisfy `EXP_PERIOD+TOL < TIMEOUT < 2^CNT_W`.

- `clk`  in  1  fast system clock, same clock that drives the divider.
- `rst`  in  1  reset, asynchronous, active-high.
- `clk_div_in`  in  1  divided clock, synchronous to `clk` (divider output register).
- `clr_err`  in  1  clears sticky `timeout_err`.
- `rise_tick`  out  1  one-cycle pulse per rising edge of `clk_div_in`.
- `fall_tick`  out  1  one-cycle pulse per falling edge.
- `period`  out  CNT_W  last measured rise-to-rise period in cycles.
- `high_time`  out  CNT_W  last measured high time in cycles.
- `period_valid`  out  1  `period` holds a real measurement.
- `locked`  out  1  divider judged stable.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- Sample register `s_q <= clk_div_in` each cycle. `rise_det = clk_div_in & ~s_q`, `fall_det = ~clk_div_in & s_q` (internal, combinational).
- `rise_tick <= rise_det`, `fall_tick <= fall_det`.
- `per_cnt`: on `rise_det` loads 1 and `period <= per_cnt`; otherwise increments, saturating at `2^CNT_W-1`.
- `hi_cnt`: on `rise_det` loads 1. Increments while `clk_div_in` = 1, saturating. On `fall_det`, `high_time <= hi_cnt`.
- In-tolerance test: `|per_cnt - EXP_PERIOD| <= TOL`, computed in CNT_W+1 bits, no wrap.
- FSM states: IDLE, MEASURE, LOCKED, FAULT. `good_cnt` counts 0..LOCK_CNT.
  - IDLE: on `rise_det` -> MEASURE, `good_cnt=0`, no period captured (first edge only arms `per_cnt`).
  - MEASURE: on `rise_det`, `period_valid<=1`; if in tolerance, `good_cnt++`, and reaching LOCK_CNT -> LOCKED; otherwise `good_cnt=0`. Without `rise_det`, `per_cnt==TIMEOUT` -> FAULT.
  - LOCKED: `rise_det` out of tolerance -> MEASURE, `good_cnt=0`. `per_cnt==TIMEOUT` -> FAULT.
  - FAULT: `timeout_err<=1`, `period_valid<=0`; on `rise_det` -> MEASURE, `good_cnt=0`.
- `locked` is decoded as state==LOCKED from the state register.
- `period` and `high_time` are captured in every state except that IDLE's first edge does not update `period`.

## Timing
- Reset (async, immediate, no clock needed): all outputs 0, `s_q=0`, counters 0, state IDLE. Deassertion is sampled on the next `clk` edge.
- Latency: tick outputs are high the cycle after `clk_div_in` is first sampled at its new level. `period`, `high_time`, state and `locked` update on the same edge as the tick.
- Simultaneous `rise_det` and `per_cnt==TIMEOUT`: the rise wins, with no fault.
- Simultaneous timeout entry and `clr_err`: the set wins, so `timeout_err` stays 1.
- `clr_err` outside FAULT entry clears `timeout_err` on the next edge. It does not change state.
- `rst` asserted mid-lock aborts any measurement. Lock requires the full IDLE->MEASURE sequence again.

## Test plan
- Reset: assert `rst` with `clk` stopped -> all outputs 0 immediately. Release -> outputs remain 0 while `clk_div_in`=0.
- Clean 0011 pattern (divide-by-4), defaults: `rise_tick`/`fall_tick` every 4 cycles, 2 cycles apart. `period`=4, `high_time`=2. `period_valid` rises with the 2nd rise tick. `locked` rises with the 4th rise tick.
- While locked, stretch one period to 5 -> `locked` falls with that rise tick and `period`=5. Three following periods of 4 -> `locked` rises again.
- While locked, hold `clk_div_in` low 16 cycles after a rise -> FAULT: `timeout_err`=1, `locked`=0, `period_valid`=0. Resume clocking -> relock after 3 good periods, with `timeout_err` still 1 until `clr_err` is pulsed.
- Rising edge arriving exactly when `per_cnt`=16 -> no fault, and `period`=16 is reported out of tolerance.
- Pulse `clr_err` on the cycle FAULT is entered -> `timeout_err`=1. Pulse `rst` mid-lock -> `locked`=0 asynchronously.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Watches a divided clock sampled in the fast clk domain: edge ticks, period/high-time
// measurement, lock qualification and a sticky timeout for a stalled divider.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div_in,
  input  logic             clr_err,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout_err
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]    EXP_X     = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_X     = (CNT_W + 1)'(TOL);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED,
    FAULT
  } state_t;

  state_t             state;
  logic               s_q;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   hi_cnt;
  logic [GOOD_W-1:0]  good_cnt;

  logic               rise_det;
  logic               fall_det;
  logic               in_tol;
  logic               timeout_hit;
  logic               enter_fault;
  logic [CNT_W:0]     per_x;
  logic [CNT_W:0]     dev;

  // Deviation is formed one bit wider than the counter so it never wraps.
  always_comb begin
    rise_det    = clk_div_in & ~s_q;
    fall_det    = ~clk_div_in & s_q;
    per_x       = {1'b0, per_cnt};
    dev         = (per_x >= EXP_X) ? (per_x - EXP_X) : (EXP_X - per_x);
    in_tol      = (dev <= TOL_X);
    timeout_hit = (per_cnt == TIMEOUT_C);
    enter_fault = ~rise_det & timeout_hit & ((state == MEASURE) || (state == LOCKED));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
    end else begin
      s_q       <= clk_div_in;
      rise_tick <= rise_det;
      fall_tick <= fall_det;

      if (rise_det) begin
        per_cnt <= CNT_ONE;
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + CNT_ONE;
      end

      if (rise_det) begin
        hi_cnt <= CNT_ONE;
      end else if (clk_div_in && (hi_cnt != CNT_MAX)) begin
        hi_cnt <= hi_cnt + CNT_ONE;
      end

      if (fall_det) begin
        high_time <= hi_cnt;
      end

      // The arming edge out of IDLE has no preceding rise, so its count is meaningless.
      if (rise_det && (state != IDLE)) begin
        period <= per_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      good_cnt     <= '0;
      period_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (enter_fault) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rise_det) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (rise_det) begin
            period_valid <= 1'b1;
            if (in_tol) begin
              if (good_cnt == (LOCK_C - GOOD_ONE)) begin
                state    <= LOCKED;
                good_cnt <= LOCK_C;
              end else begin
                good_cnt <= good_cnt + GOOD_ONE;
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (timeout_hit) begin
            state        <= FAULT;
            period_valid <= 1'b0;
            good_cnt     <= '0;
          end
        end
        LOCKED: begin
          if (rise_det) begin
            if (!in_tol) begin
              state    <= MEASURE;
              good_cnt <= '0;
            end
          end else if (timeout_hit) begin
            state        <= FAULT;
            period_valid <= 1'b0;
            good_cnt     <= '0;
          end
        end
        FAULT: begin
          if (rise_det) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          good_cnt <= '0;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a timestamp-based reference model predicts every
// tick and status change; an independent monitor pops and compares as the DUT reports them.
module tb_clk_div_monitor;

  localparam int CNT_W      = 8;
  localparam int EXP_PERIOD = 4;
  localparam int TOL        = 0;
  localparam int LOCK_CNT   = 3;
  localparam int TIMEOUT    = 16;
  localparam int SAT        = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clk_div_in = 1'b0;
  logic             clr_err = 1'b0;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             timeout_err;

  bit clkRun = 1'b0;
  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  clk_div_monitor #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .clk_div_in(clk_div_in), .clr_err(clr_err),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .period(period), .high_time(high_time),
    .period_valid(period_valid), .locked(locked), .timeout_err(timeout_err)
  );

  // Gated clock so reset can be exercised with the clock stopped.
  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  always @(posedge clk) edgeCount <= edgeCount + 1;

  typedef struct {
    int stamp;
    bit rise;
    bit fall;
    int per;
    int hi;
    bit pv;
    bit lk;
    bit te;
  } exp_t;

  exp_t expQ[$];

  // Reference model state, expressed as timestamps of observed edges.
  bit mPrevLvl, mArmed, mFaulted, mLocked, mPv, mTe;
  int mGood, mLastRise, mPeriod, mHigh;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic bit inTol(input int p);
    int d;
    d = (p > EXP_PERIOD) ? (p - EXP_PERIOD) : (EXP_PERIOD - p);
    return d <= TOL;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  task automatic modelReset();
    mPrevLvl = 0; mArmed = 0; mFaulted = 0; mLocked = 0; mPv = 0; mTe = 0;
    mGood = 0; mLastRise = 0; mPeriod = 0; mHigh = 0;
  endtask

  // Predicts what the DUT shows after clock edge e, given the level and clear it sampled there.
  task automatic modelEdge(input bit lvl, input bit clr, input int e);
    bit rise, fall, faultNow, oldPv, oldLk, oldTe;
    exp_t x;
    rise = lvl && !mPrevLvl;
    fall = !lvl && mPrevLvl;
    faultNow = 0;
    oldPv = mPv; oldLk = mLocked; oldTe = mTe;
    if (rise) begin
      if (!mArmed) begin
        mArmed = 1;
        mGood = 0;
      end else begin
        mPeriod = sat(e - mLastRise);
        if (mFaulted) begin
          mFaulted = 0;
          mGood = 0;
        end else if (mLocked) begin
          if (!inTol(mPeriod)) begin
            mLocked = 0;
            mGood = 0;
          end
        end else begin
          mPv = 1;
          if (inTol(mPeriod)) begin
            mGood++;
            if (mGood == LOCK_CNT) mLocked = 1;
          end else begin
            mGood = 0;
          end
        end
      end
      mLastRise = e;
    end else if (mArmed && !mFaulted && ((e - mLastRise) == TIMEOUT)) begin
      faultNow = 1; mFaulted = 1; mLocked = 0; mPv = 0; mGood = 0;
    end
    if (fall) mHigh = sat(e - mLastRise);
    if (faultNow) mTe = 1;
    else if (clr) mTe = 0;
    mPrevLvl = lvl;
    if (rise || fall || (mPv != oldPv) || (mLocked != oldLk) || (mTe != oldTe)) begin
      x.stamp = e; x.rise = rise; x.fall = fall; x.per = mPeriod; x.hi = mHigh;
      x.pv = mPv; x.lk = mLocked; x.te = mTe;
      expQ.push_back(x);
    end
  endtask

  task automatic applyStimulus(input logic lvl, input logic clr);
    clk_div_in = lvl;
    clr_err = clr;
    @(posedge clk);
    #1;
    modelEdge(lvl, clr, edgeCount);
  endtask

  // One divided-clock period: low first, then high for the last hi cycles.
  task automatic runPeriod(input int per, input int hi, input int clrAt);
    for (int i = 0; i < per; i++) applyStimulus(i >= (per - hi), i == clrAt);
  endtask

  task automatic holdLevel(input logic lvl, input int n, input int clrAt);
    for (int i = 0; i < n; i++) applyStimulus(lvl, i == clrAt);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1;
    rst = 1'b1;
    clk_div_in = 1'b0;
    clr_err = 1'b0;
    #1;
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_period_valid", period_valid, 0);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: any tick or status change is a DUT event and must match the next prediction.
  bit monPv = 0, monLk = 0, monTe = 0;
  exp_t got;
  always @(negedge clk) begin
    if (rst) begin
      monPv = period_valid; monLk = locked; monTe = timeout_err;
    end else begin
      if (rise_tick || fall_tick || (period_valid != monPv) || (locked != monLk) || (timeout_err != monTe)) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: edge %0d rise %0d fall %0d pv %0d locked %0d te %0d, expected no event",
                   edgeCount, rise_tick, fall_tick, period_valid, locked, timeout_err);
        end else begin
          got = expQ.pop_front();
          checkOutput("event_edge", edgeCount, got.stamp);
          checkOutput("rise_tick", rise_tick, got.rise);
          checkOutput("fall_tick", fall_tick, got.fall);
          checkOutput("period", period, got.per);
          checkOutput("high_time", high_time, got.hi);
          checkOutput("period_valid", period_valid, got.pv);
          checkOutput("locked", locked, got.lk);
          checkOutput("timeout_err", timeout_err, got.te);
        end
      end
      monPv = period_valid; monLk = locked; monTe = timeout_err;
    end
  end

  initial begin
    int r, per, hi, clrAt;
    modelReset();

    // Asynchronous reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    checkOutput("init_rise_tick", rise_tick, 0);
    checkOutput("init_fall_tick", fall_tick, 0);
    checkOutput("init_period", period, 0);
    checkOutput("init_high_time", high_time, 0);
    checkOutput("init_period_valid", period_valid, 0);
    checkOutput("init_locked", locked, 0);
    checkOutput("init_timeout_err", timeout_err, 0);
    #10 clkRun = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    holdLevel(0, 4, -1);
    checkOutput("post_rst_period_valid", period_valid, 0);
    checkOutput("post_rst_locked", locked, 0);

    // Clean divide-by-4 until lock.
    repeat (4) runPeriod(4, 2, -1);
    checkOutput("clean_locked", locked, 1);
    checkOutput("clean_period", period, 4);
    checkOutput("clean_high_time", high_time, 2);
    repeat (2) runPeriod(4, 2, -1);

    // Stretched period drops lock; three good periods regain it.
    runPeriod(5, 2, -1);
    checkOutput("stretch_locked", locked, 0);
    checkOutput("stretch_period", period, 5);
    repeat (3) runPeriod(4, 2, -1);
    checkOutput("relock_locked", locked, 1);

    // Stall with clr_err landing on the fault-entry edge.
    holdLevel(0, 20, 14);
    checkOutput("fault_timeout_err", timeout_err, 1);
    checkOutput("fault_locked", locked, 0);
    checkOutput("fault_period_valid", period_valid, 0);
    repeat (4) runPeriod(4, 2, -1);
    checkOutput("fault_relock", locked, 1);
    checkOutput("fault_sticky", timeout_err, 1);
    runPeriod(4, 2, 0);
    checkOutput("clr_timeout_err", timeout_err, 0);

    // Rise exactly at the timeout count wins over the fault.
    runPeriod(16, 2, -1);
    checkOutput("edge16_period", period, 16);
    checkOutput("edge16_locked", locked, 0);
    checkOutput("edge16_timeout_err", timeout_err, 0);
    repeat (3) runPeriod(4, 2, -1);

    // Counter saturation on long high and long low phases.
    holdLevel(1, 300, -1);
    holdLevel(0, 300, -1);
    checkOutput("sat_high_time", high_time, SAT);
    runPeriod(4, 2, -1);
    checkOutput("sat_period", period, SAT);

    // Reset in the middle of a locked period.
    repeat (4) runPeriod(4, 2, -1);
    applyStimulus(0, 0);
    resetDut();
    repeat (4) runPeriod(4, 2, -1);
    checkOutput("post_reset_relock", locked, 1);

    // Randomized periods, duty cycles, clears and occasional resets.
    for (int b = 0; b < 250; b++) begin
      r = $urandom_range(0, 19);
      if (r < 14) begin
        per = 4; hi = 2;
      end else if (r < 17) begin
        per = $urandom_range(3, 6); hi = $urandom_range(1, per - 1);
      end else begin
        per = $urandom_range(6, 24); hi = $urandom_range(1, per - 1);
      end
      clrAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, per - 1)) : -1;
      if ($urandom_range(0, 99) == 0) resetDut();
      runPeriod(per, hi, clrAt);
    end

    holdLevel(0, 3, -1);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
